// File: rtl/fir_frame_buffer.sv
// Ping-pong frame buffer between the FIR output and the FFT input: packs the
// sample stream into N-sample frames and hands them on with valid/ready.
module fir_frame_buffer #(
    parameter int DW = 16,
    parameter int N  = 16,
    parameter int CW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            fir_valid,
    input  logic [DW-1:0]   fir_d,
    output logic            frame_valid,
    input  logic            frame_ready,
    output logic [N*DW-1:0] frame_data,
    output logic            overflow,
    output logic [CW-1:0]   frame_cnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, FILL, DROP} state_t;

    state_t            state_q, state_d, eff;
    logic [IW-1:0]     idx_q, idx_d;
    logic [1:0]        full_q, full_d;
    logic              wr_bank_q, wr_bank_d;
    logic              rd_bank_q, rd_bank_d;
    logic [N*DW-1:0]   bank_q [2];
    logic [N*DW-1:0]   bank_d [2];
    logic              frame_valid_q, frame_valid_d;
    logic [N*DW-1:0]   frame_data_q, frame_data_d;
    logic              overflow_q, overflow_d;
    logic [CW-1:0]     frame_cnt_q, frame_cnt_d;
    logic              accept, fill, tgt;

    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        full_d        = full_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        bank_d[0]     = bank_q[0];
        bank_d[1]     = bank_q[1];
        overflow_d    = overflow_q;
        frame_cnt_d   = frame_cnt_q;
        eff           = state_q;
        fill          = 1'b0;
        tgt           = wr_bank_q;
        accept        = frame_valid_q & frame_ready;

        // Release happens first so a bank freed this cycle is seen as empty below.
        if (accept) begin
            full_d[rd_bank_q] = 1'b0;
            rd_bank_d         = ~rd_bank_q;
            frame_cnt_d       = frame_cnt_q + 1'b1;
        end

        if (fir_valid) begin
            if (state_q == IDLE) begin
                if (full_d[wr_bank_q]) begin
                    eff        = DROP;
                    overflow_d = 1'b1;
                end else begin
                    eff = FILL;
                end
            end
            fill    = (eff == FILL);
            state_d = eff;
            idx_d   = idx_q + 1'b1;
            if (fill)
                bank_d[wr_bank_q][int'(idx_q)*DW +: DW] = fir_d;
            if (idx_q == IW'(N-1)) begin
                if (fill) begin
                    full_d[wr_bank_q] = 1'b1;
                    tgt               = ~wr_bank_q;
                    wr_bank_d         = ~wr_bank_q;
                end
                if (full_d[tgt]) begin
                    state_d    = DROP;
                    overflow_d = 1'b1;
                end else begin
                    state_d = FILL;
                end
            end
        end

        // Output registers load next-state values so a frame shows the same edge it completes.
        frame_valid_d = full_d[rd_bank_d];
        frame_data_d  = bank_d[rd_bank_d];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            idx_q         <= '0;
            full_q        <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            bank_q[0]     <= '0;
            bank_q[1]     <= '0;
            frame_valid_q <= 1'b0;
            frame_data_q  <= '0;
            overflow_q    <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            full_q        <= full_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            bank_q[0]     <= bank_d[0];
            bank_q[1]     <= bank_d[1];
            frame_valid_q <= frame_valid_d;
            frame_data_q  <= frame_data_d;
            overflow_q    <= overflow_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign frame_valid = frame_valid_q;
    assign frame_data  = frame_data_q;
    assign overflow    = overflow_q;
    assign frame_cnt   = frame_cnt_q;

endmodule
